load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 50 +++++
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit_align.sv | 59 +++++
 rtl/load_store_unit.sv | 108 ++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
// - LSU_XLEN: data and address width (only 32 is supported).
// - F3_*: RISC-V funct3 codes for the access size and sign.
// - lsu_state_e: FSM state encodings.
// - lsu_req_t: request fields latched when a request is accepted.
// - req_err(): the illegal-funct3 and misalignment check, done before any memory access.
package load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RD,
    S_LD_CAP,
    S_ST_RD,
    S_ST_MRG,
    S_ST_WR,
    S_RSP,
    S_ERR_RSP
  } lsu_state_e;

  // Only what the later states still need: the size code, the byte lane and
  // the sub-word store data. SW data goes straight to mem_wdata on accept.
  typedef struct packed {
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } lsu_req_t;

  function automatic logic req_err(input logic       store,
                                   input logic [2:0] funct3,
                                   input logic [1:0] lane);
    logic legal;
    logic misaligned;
    if (store) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else       legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
    // funct3[1:0] is the size for every legal code: 00 byte, 01 half, 10 word.
    misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                 ((funct3[1:0] == 2'b10) && (lane != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle around the load/store unit.
// - Request channel from EX: req_valid/req_ready, req_store, req_funct3,
//   req_addr, req_wdata.
// - Response channel back to EX: resp_valid/resp_ready, resp_rdata, resp_err.
// - data_mem port: mem_read, mem_write, mem_addr (word index), mem_wdata,
//   mem_rdata.
// Modports:
// - slave: the load/store unit's view.
// - master: the surrounding system (EX stage plus data_mem).
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_store;
  logic [2:0]          req_funct3;
  logic [LSU_XLEN-1:0] req_addr;
  logic [LSU_XLEN-1:0] req_wdata;

  logic                resp_valid;
  logic                resp_ready;
  logic [LSU_XLEN-1:0] resp_rdata;
  logic                resp_err;

  logic                mem_read;
  logic                mem_write;
  logic [LSU_XLEN-1:0] mem_addr;
  logic [LSU_XLEN-1:0] mem_wdata;
  logic [LSU_XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the load/store unit.
// - funct3: access size and sign.
// - lane: byte address bits [1:0].
// - rdata: word read from data_mem.
// - wdata: store data; only the low byte or halfword is used.
// - load_data: selected lane, sign- or zero-extended for loads.
// - merged: rdata with the store byte or halfword replaced at the lane.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          lane,
  input  logic [LSU_XLEN-1:0] rdata,
  input  logic [15:0]         wdata,
  output logic [LSU_XLEN-1:0] load_data,
  output logic [LSU_XLEN-1:0] merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path can leave one unassigned and infer a latch.
    ld_byte   = rdata[7:0];
    ld_half   = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    merged    = rdata;

    case (lane)
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      2'd3:    ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase

    case (funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'h0, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'h0, ld_half};
      default: load_data = rdata;
    endcase

    if (funct3[1:0] == 2'b00) begin
      case (lane)
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        2'd3:    merged[31:24] = wdata[7:0];
        default: merged[7:0]   = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      merged[31:16] = wdata;
    end else begin
      merged[15:0] = wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator-side controller for the word-wide data_mem.
// - clk: rising-edge clock.
// - rst_n: synchronous, active-low reset.
// - bus (slave modport): the request/response channels to EX and the
//   data_mem strobe/address/data port.
// Accepts one request at a time and checks it before touching memory.
// Loads are read, captured and extended. SW is written directly. SB/SH run a
// read-modify-write. Exactly one response is returned per accepted request.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  lsu_state_e      state;
  lsu_req_t        req_q;
  logic            accept;
  logic            err;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;

  assign bus.req_ready = (state == S_IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;
  assign err           = req_err(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

  // Strobes decode straight from the state register. They are gated by rst_n
  // so that a reset in flight silences memory in the same cycle.
  assign bus.mem_read  = rst_n && ((state == S_LD_RD) || (state == S_ST_RD));
  assign bus.mem_write = rst_n && (state == S_ST_WR);

  load_store_unit_align u_align (
    .funct3    (req_q.funct3),
    .lane      (req_q.lane),
    .rdata     (bus.mem_rdata),
    .wdata     (req_q.wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // NOTE: all state in this block uses non-blocking assignments, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the request latch is reset too, even though nothing reads it
      // in IDLE. This keeps the whole datapath deterministic after reset.
      state          <= S_IDLE;
      req_q          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_q.funct3   <= bus.req_funct3;
            req_q.lane     <= bus.req_addr[1:0];
            req_q.wdata    <= bus.req_wdata[15:0];
            bus.mem_addr   <= {2'b00, bus.req_addr[XLEN-1:2]};
            bus.resp_rdata <= '0;
            bus.resp_err   <= err;
            if (err) begin
              bus.resp_valid <= 1'b1;
              state          <= S_ERR_RSP;
            end else if (!bus.req_store) begin
              state <= S_LD_RD;
            end else if (bus.req_funct3 == F3_W) begin
              bus.mem_wdata <= bus.req_wdata;
              state         <= S_ST_WR;
            end else begin
              state <= S_ST_RD;
            end
          end
        end
        S_LD_RD:  state <= S_LD_CAP;
        S_LD_CAP: begin
          bus.resp_rdata <= load_data;
          bus.resp_valid <= 1'b1;
          state          <= S_RSP;
        end
        S_ST_RD:  state <= S_ST_MRG;
        S_ST_MRG: begin
          bus.mem_wdata <= merged;
          state         <= S_ST_WR;
        end
        S_ST_WR: begin
          bus.resp_valid <= 1'b1;
          state          <= S_RSP;
        end
        S_RSP, S_ERR_RSP: begin
          // The response registers hold until the consumer takes them.
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.mem_addr   <= '0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit, with a small data_mem model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // data_mem model: synchronous read, write commits at the edge.
  logic [31:0] mem [0:15] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end

  // Strobe monitor.
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_read) begin
      rd_cnt       <= rd_cnt + 1;
      rd_cyc       <= cyc;
      last_rd_addr <= bus.mem_addr;
    end
    if (bus.mem_write) begin
      wr_cnt       <= wr_cnt + 1;
      wr_cyc       <= cyc;
      last_wr_addr <= bus.mem_addr;
      last_wr_data <= bus.mem_wdata;
    end
    if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and consume its response with resp_ready=1.
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_rd, input int exp_wr);
    int lat;
    int rd0;
    int wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request fields: the unit must use the latched copy.
    bus.req_valid  = 1'b0;
    bus.req_store  = ~st;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, ".reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_rd > 0) check({tag, ".rd_addr"}, last_rd_addr, {2'b00, addr[31:2]});
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, ".idle_addr"}, bus.mem_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] held_rdata;
    int          lat;
    int          rd0;
    int          wr0;

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;
    rst_n          = 1'b0;

    // Reset behaviour.
    repeat (3) @(negedge clk);
    check("rst.req_ready_low", 32'(bus.req_ready), 32'd0);
    check("rst.mem_read_low", 32'(bus.mem_read), 32'd0);
    check("rst.mem_write_low", 32'(bus.mem_write), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    check("rst.resp_err", 32'(bus.resp_err), 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);

    // SW then LW of the same word.
    run_req("sw8", 1'b1, F3_W, 32'h8, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
    check("sw8.wr_addr", last_wr_addr, 32'd2);
    check("sw8.wr_data", last_wr_data, 32'hDEAD_BEEF);
    run_req("lw8", 1'b0, F3_W, 32'h8, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1, 0);

    // Extension checks against 0xDEADBEEF.
    run_req("lb_b",  1'b0, F3_B,  32'hB, 32'h0, 3, 32'hFFFF_FFDE, 1'b0, 1, 0);
    run_req("lbu_b", 1'b0, F3_BU, 32'hB, 32'h0, 3, 32'h0000_00DE, 1'b0, 1, 0);
    run_req("lh_a",  1'b0, F3_H,  32'hA, 32'h0, 3, 32'hFFFF_DEAD, 1'b0, 1, 0);
    run_req("lhu_8", 1'b0, F3_HU, 32'h8, 32'h0, 3, 32'h0000_BEEF, 1'b0, 1, 0);
    run_req("lb_8",  1'b0, F3_B,  32'h8, 32'h0, 3, 32'hFFFF_FFEF, 1'b0, 1, 0);

    // SB read-modify-write at byte lane 1.
    run_req("sb9", 1'b1, F3_B, 32'h9, 32'h0000_0012, 4, 32'h0, 1'b0, 1, 1);
    check("sb9.rd_to_wr", 32'(wr_cyc - rd_cyc), 32'd2);
    check("sb9.wr_addr", last_wr_addr, 32'd2);
    check("sb9.wr_data", last_wr_data, 32'hDEAD_12EF);
    run_req("lw8_after_sb", 1'b0, F3_W, 32'h8, 32'h0, 3, 32'hDEAD_12EF, 1'b0, 1, 0);

    // SH to the upper half of a zero word.
    run_req("sh2", 1'b1, F3_H, 32'h2, 32'h7777_ABCD, 4, 32'h0, 1'b0, 1, 1);
    run_req("lw0", 1'b0, F3_W, 32'h0, 32'h0, 3, 32'hABCD_0000, 1'b0, 1, 0);

    // Error cases: response at +1, no strobes.
    run_req("lw6_mis",  1'b0, F3_W,   32'h6, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("lh5_mis",  1'b0, F3_H,   32'h5, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("st_f3_100", 1'b1, 3'b100, 32'h0, 32'h1, 1, 32'h0, 1'b1, 0, 0);
    run_req("sw_mis",   1'b1, F3_W,   32'h9, 32'h5, 1, 32'h0, 1'b1, 0, 0);

    // Backpressure on a load response.
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'hA;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    bus.req_addr = 32'h0;  // req_valid stays high; it must be ignored while busy
    while (bus.resp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("bp.latency", 32'(lat), 32'd3);
    held_rdata = 32'hFFFF_DEAD;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.valid_held", 32'(bus.resp_valid), 32'd1);
      check("bp.rdata_held", bus.resp_rdata, held_rdata);
      check("bp.err_held", 32'(bus.resp_err), 32'd0);
      check("bp.req_ready", 32'(bus.req_ready), 32'd0);
    end
    check("bp.no_reads", 32'(rd_cnt - rd0), 32'd0);
    check("bp.no_writes", 32'(wr_cnt - wr0), 32'd0);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.valid_drop", 32'(bus.resp_valid), 32'd0);
    check("bp.ready_back", 32'(bus.req_ready), 32'd1);

    // Reset in the middle of an SH read-modify-write.
    run_req("sw_c", 1'b1, F3_W, 32'hC, 32'h1122_3344, 2, 32'h0, 1'b0, 0, 1);
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'hE;
    bus.req_wdata  = 32'h0000_5555;
    @(posedge clk);             // accept -> ST_RD
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);             // -> ST_MRG
    @(negedge clk);
    rst_n = 1'b0;               // sampled at the edge ending ST_MRG
    @(posedge clk);
    @(negedge clk);
    check("rmw_rst.no_write_in_rst", 32'(bus.mem_write), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rmw_rst.req_ready", 32'(bus.req_ready), 32'd1);
    check("rmw_rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("rmw_rst.no_writes", 32'(wr_cnt - wr0), 32'd0);
    check("rmw_rst.mem_word", mem[3], 32'h1122_3344);
    check("rmw_rst.resp_still_low", 32'(bus.resp_valid), 32'd0);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
